io_input_block: RTL and testbench

- Input-side I/O device for the 8-bit CPU.
- An external source (testbench or host model) pushes bytes into a small FIFO using a valid/ready handshake.
- The CPU reads the FIFO head, or a status byte, onto main_bus through an outctl select code.
- It is the from-device counterpart of the integer/char output block and sits on the same main_bus.

---
 rtl/io_pkg.sv | 14 +
 rtl/io_input_block_if.sv | 13 +
 rtl/io_input_fifo.sv | 65 ++++++
 rtl/io_input_block.sv | 90 +++++++++
 tb/tb_io_input_block.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared constants for the CPU I/O blocks on main_bus.
// Select codes, status bit positions and bus width.
package io_pkg;

    localparam int BUS_W = 8;

    localparam logic [3:0] SEL_DATA = 4'h4;
    localparam logic [3:0] SEL_STAT = 4'h5;

    localparam int ST_NEMPTY = 0;
    localparam int ST_FULL   = 1;
    localparam int ST_OVF    = 2;

endpackage

// File: rtl/io_input_block_if.sv
// Byte source handshake into the input block.
// master = external source, slave = io_input_block.
interface io_input_block_if;
    import io_pkg::*;

    logic [BUS_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/io_input_fifo.sv
// Input byte FIFO: storage, pointers and occupancy count.
// Pop on empty is ignored and dout reads zero.
module io_input_fifo
    import io_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             out_rst,
    input  logic             push,
    input  logic             pop,
    input  logic [BUS_W-1:0] din,
    output logic [BUS_W-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    logic [BUS_W-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              push_ok, pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_FULL);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge out_rst) begin
        if (out_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately not reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/io_input_block.sv
// Input-side I/O device: source bytes queue in a FIFO, CPU reads head/status.
// Optional sticky overflow flag: define IO_INPUT_OVERFLOW_EN.
module io_input_block
    import io_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             out_rst,
    inout  wire  [BUS_W-1:0] main_bus,
    input  logic [3:0]       outctl,
    io_input_block_if.slave  src,
    output logic             empty,
    output logic             full
);

    logic             sel_data, sel_stat;
    logic             push;
    logic             ovf;
    logic [BUS_W-1:0] head;
    logic [BUS_W-1:0] status;
    logic [BUS_W-1:0] bus_val;
    logic             bus_oe;

    assign sel_data     = (outctl == SEL_DATA);
    assign sel_stat     = (outctl == SEL_STAT);
    assign src.in_ready = !full;
    assign push         = src.in_valid && !full;

    io_input_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .out_rst (out_rst),
        .push    (push),
        .pop     (sel_data),
        .din     (src.in_data),
        .dout    (head),
        .empty   (empty),
        .full    (full)
    );

`ifdef IO_INPUT_OVERFLOW_EN
    logic ovf_q, ovf_d;

    // A new overflow wins over the clear-on-status-read.
    always_comb begin
        ovf_d = ovf_q;
        if (sel_stat) ovf_d = 1'b0;
        if (src.in_valid && full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge out_rst) begin
        if (out_rst) ovf_q <= 1'b0;
        else         ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    always_comb begin
        status            = '0;
        status[ST_NEMPTY] = !empty;
        status[ST_FULL]   = full;
        status[ST_OVF]    = ovf;
    end

    always_comb begin
        bus_oe  = 1'b0;
        bus_val = '0;
        unique case (1'b1)
            sel_data: begin
                bus_oe  = 1'b1;
                bus_val = head;
            end
            sel_stat: begin
                bus_oe  = 1'b1;
                bus_val = status;
            end
            default: ;
        endcase
    end

    assign main_bus = bus_oe ? bus_val : {BUS_W{1'bz}};

endmodule

// File: tb/tb_io_input_block.sv
// Directed bench for io_input_block; released bus reads 8'hFF via pullups.
// Define IO_INPUT_OVERFLOW_EN for both bench and RTL to cover the ovf flag.
module tb_io_input_block;
    import io_pkg::*;

    localparam logic [7:0] REL = 8'hFF;

    logic       clk = 1'b0;
    logic       out_rst;
    logic [3:0] outctl;
    logic       empty, full;
    wire  [7:0] main_bus;

    int checks = 0;
    int errors = 0;

    io_input_block_if sif ();

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (main_bus[i]);
    end

    io_input_block #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk      (clk),
        .out_rst  (out_rst),
        .main_bus (main_bus),
        .outctl   (outctl),
        .src      (sif.slave),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        sif.in_data  = b;
        sif.in_valid = 1'b1;
        cyc();
        sif.in_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        outctl = SEL_DATA;
        #3;
        chk(tag, main_bus, exp);
        cyc();
        outctl = 4'h0;
    endtask

    task automatic stat(input string tag, input logic [7:0] exp);
        outctl = SEL_STAT;
        #3;
        chk(tag, main_bus, exp);
        cyc();
        outctl = 4'h0;
    endtask

    logic [7:0] exp_v;

    initial begin
        out_rst      = 1'b1;
        outctl       = 4'h0;
        sif.in_data  = 8'h99;
        sif.in_valid = 1'b1;
        #1;
        chk("rst_empty", {7'b0, empty}, 8'h01);
        chk("rst_full", {7'b0, full}, 8'h00);
        chk("rst_ready", {7'b0, sif.in_ready}, 8'h01);
        cyc();
        cyc();
        sif.in_valid = 1'b0;
        out_rst      = 1'b0;
        #1;
        chk("rst_dominates_push", {7'b0, empty}, 8'h01);

        // Async reset mid-cycle with data queued
        push(8'h77);
        chk("pre_rst_nonempty", {7'b0, empty}, 8'h00);
        #2;
        out_rst = 1'b1;
        #1;
        chk("async_empty", {7'b0, empty}, 8'h01);
        chk("async_full", {7'b0, full}, 8'h00);
        chk("async_ready", {7'b0, sif.in_ready}, 8'h01);
        chk("async_bus_z", main_bus, REL);
        outctl = SEL_STAT;
        #1;
        chk("async_stat", main_bus, 8'h00);
        out_rst = 1'b0;
        outctl  = 4'h0;
        cyc();

        // Single byte
        push(8'h41);
        stat("single_stat", 8'h01);
        rd("single_data", 8'h41);
        chk("single_empty", {7'b0, empty}, 8'h01);
        rd("underflow_data", 8'h00);
        chk("underflow_empty", {7'b0, empty}, 8'h01);

        // Fill and wrap
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        chk("fill_full", {7'b0, full}, 8'h01);
        chk("fill_ready", {7'b0, sif.in_ready}, 8'h00);
        stat("fill_stat", 8'h03);
        rd("pop_10", 8'h10);
        rd("pop_11", 8'h11);
        push(8'h14);
        push(8'h15);
        for (int i = 0; i < 4; i++) rd("wrap_pop", 8'h12 + 8'(i));
        chk("wrap_empty", {7'b0, empty}, 8'h01);

        // Push and pop in the same cycle, two entries held
        push(8'h20);
        push(8'h21);
        sif.in_data  = 8'hAA;
        sif.in_valid = 1'b1;
        rd("simul_old_head", 8'h20);
        sif.in_valid = 1'b0;
        rd("simul_pop_21", 8'h21);
        rd("simul_pop_aa", 8'hAA);
        chk("simul_empty", {7'b0, empty}, 8'h01);

        // Push and pop from empty
        sif.in_data  = 8'hBB;
        sif.in_valid = 1'b1;
        rd("empty_simul_bus", 8'h00);
        sif.in_valid = 1'b0;
        chk("empty_simul_cnt1", {7'b0, empty}, 8'h00);
        rd("empty_simul_bb", 8'hBB);
        chk("empty_simul_drain", {7'b0, empty}, 8'h01);

        // Hold while full
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
        sif.in_data  = 8'h55;
        sif.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("hold_ready", {7'b0, sif.in_ready}, 8'h00);
            cyc();
        end
        outctl = SEL_DATA;
        #3;
        chk("hold_pop_30", main_bus, 8'h30);
        chk("hold_ready_pop", {7'b0, sif.in_ready}, 8'h00);
        cyc();
        outctl = 4'h0;
        chk("hold_ready_rise", {7'b0, sif.in_ready}, 8'h01);
        cyc();
        sif.in_valid = 1'b0;
        chk("hold_refull", {7'b0, full}, 8'h01);
`ifdef IO_INPUT_OVERFLOW_EN
        exp_v = 8'h07;
`else
        exp_v = 8'h03;
`endif
        stat("ovf_stat1", exp_v);
        stat("ovf_stat2", 8'h03);
        rd("hold_pop_31", 8'h31);
        rd("hold_pop_32", 8'h32);
        rd("hold_pop_33", 8'h33);
        rd("hold_pop_55", 8'h55);
        chk("hold_empty", {7'b0, empty}, 8'h01);

        // Bus release across all select codes
        push(8'h60);
        push(8'h61);
        for (int c = 0; c < 16; c++) begin
            outctl = 4'(c);
            #3;
            if (c == 4)      exp_v = 8'h60;
            else if (c == 5) exp_v = 8'h01;
            else             exp_v = REL;
            chk($sformatf("sel_%0d", c), main_bus, exp_v);
            cyc();
        end
        outctl = 4'h0;
        rd("sel_after_61", 8'h61);
        chk("sel_final_empty", {7'b0, empty}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
